// File: rtl/eprisc_ttl_transmitter.sv
// Queued 8-bit TTL serial transmitter: byte FIFO feeding an 8N1 framer.
// Define TTL_TX_PARITY_EN to add an even-parity bit (8E1 framing).
module eprisc_ttl_transmitter #(
    parameter int CLOCKS_PER_BIT = 256,
    parameter int FIFO_DEPTH     = 4
) (
    input  logic       iBoardClock,
    input  logic       iBoardReset,
    input  logic [7:0] iData,
    input  logic       iValid,
    output logic       oReady,
    output logic       oBusy,
    output logic       oTTLSerialTX
);
    localparam int BAUD_W = $clog2(CLOCKS_PER_BIT);
    localparam int PTR_W  = $clog2(FIFO_DEPTH);
    localparam int CNT_W  = $clog2(FIFO_DEPTH + 1);
    localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLOCKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(FIFO_DEPTH);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
`ifdef TTL_TX_PARITY_EN
        S_PARITY = 3'd3,
`endif
        S_STOP   = 3'd4
    } state_t;

    // transmit queue
    logic [7:0]       r_mem [FIFO_DEPTH];
    logic [PTR_W-1:0] r_wr_ptr;
    logic [PTR_W-1:0] r_rd_ptr;
    logic [CNT_W-1:0] r_count;
    logic             w_ready;
    logic             w_empty;
    logic             w_push;
    logic             w_pop;
    logic [7:0]       w_head;

    // framer
    state_t            r_state;
    state_t            w_state_next;
    logic [BAUD_W-1:0] r_baud;
    logic [BAUD_W-1:0] w_baud_next;
    logic [2:0]        r_bit;
    logic [2:0]        w_bit_next;
    logic [7:0]        r_shift;
    logic [7:0]        w_shift_next;
    logic              r_tx;
    logic              w_tx_next;
    logic              w_baud_end;
`ifdef TTL_TX_PARITY_EN
    logic              r_parity;
`endif

    assign w_ready = (r_count != CNT_FULL);
    assign w_empty = (r_count == '0);
    assign w_push  = iValid && w_ready;
    assign w_head  = r_mem[r_rd_ptr];

    always_ff @(posedge iBoardClock) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= iData;
        end
    end

    // Depth is a power of two, so the pointers wrap naturally.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CNT_W'(1);
                2'b01:   r_count <= r_count - CNT_W'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    assign w_baud_end = (r_baud == BAUD_LAST);

    always_comb begin
        w_state_next = r_state;
        w_baud_next  = r_baud + BAUD_W'(1);
        w_bit_next   = r_bit;
        w_shift_next = r_shift;
        w_pop        = 1'b0;
        case (r_state)
            S_IDLE: begin
                w_baud_next = '0;
                if (!w_empty) begin
                    w_pop        = 1'b1;
                    w_shift_next = w_head;
                    w_state_next = S_START;
                end
            end
            S_START: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_bit_next   = '0;
                    w_state_next = S_DATA;
                end
            end
            S_DATA: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    if (r_bit == 3'd7) begin
`ifdef TTL_TX_PARITY_EN
                        w_state_next = S_PARITY;
`else
                        w_state_next = S_STOP;
`endif
                    end else begin
                        w_bit_next   = r_bit + 3'd1;
                        w_shift_next = {1'b0, r_shift[7:1]};
                    end
                end
            end
`ifdef TTL_TX_PARITY_EN
            S_PARITY: begin
                if (w_baud_end) begin
                    w_baud_next  = '0;
                    w_state_next = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_baud_end) begin
                    w_baud_next = '0;
                    // Chain straight into the next frame with no idle bit.
                    if (!w_empty) begin
                        w_pop        = 1'b1;
                        w_shift_next = w_head;
                        w_state_next = S_START;
                    end else begin
                        w_state_next = S_IDLE;
                    end
                end
            end
            default: begin
                w_baud_next  = '0;
                w_state_next = S_IDLE;
            end
        endcase
    end

    // Line level is computed from the next state so it switches on the transition edge.
    always_comb begin
        w_tx_next = 1'b1;
        case (w_state_next)
            S_START:  w_tx_next = 1'b0;
            S_DATA:   w_tx_next = w_shift_next[0];
`ifdef TTL_TX_PARITY_EN
            S_PARITY: w_tx_next = r_parity;
`endif
            default:  w_tx_next = 1'b1;
        endcase
    end

    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            r_state <= S_IDLE;
            r_baud  <= '0;
            r_bit   <= '0;
            r_shift <= '0;
            r_tx    <= 1'b1;
        end else begin
            r_state <= w_state_next;
            r_baud  <= w_baud_next;
            r_bit   <= w_bit_next;
            r_shift <= w_shift_next;
            r_tx    <= w_tx_next;
        end
    end

`ifdef TTL_TX_PARITY_EN
    // Parity is latched from the whole byte at load time, before shifting starts.
    always_ff @(posedge iBoardClock) begin
        if (iBoardReset) begin
            r_parity <= 1'b0;
        end else if (w_pop) begin
            r_parity <= ^w_head;
        end
    end
`endif

    assign oReady       = w_ready;
    assign oBusy        = (r_state != S_IDLE) || !w_empty;
    assign oTTLSerialTX = r_tx;

endmodule

// File: tb/tb_eprisc_ttl_transmitter.sv
// Scoreboard bench for eprisc_ttl_transmitter: bytes queued on push, frames decoded off the line.
module tb_eprisc_ttl_transmitter;
    localparam int CPB   = 256;
    localparam int DEPTH = 4;
`ifdef TTL_TX_PARITY_EN
    localparam int NBITS = 11;
`else
    localparam int NBITS = 10;
`endif
    localparam int FRAME = NBITS * CPB;

    logic       clk   = 1'b0;
    logic       rst   = 1'b0;
    logic       valid = 1'b0;
    logic [7:0] data  = 8'h00;
    logic       ready;
    logic       busy;
    logic       tx;

    int         vectors     = 0;
    int         miscompares = 0;
    int         cyc         = 0;
    int         last_stop_cyc = -1000;
    logic [7:0] sb[$];
    int         gaps[$];

    eprisc_ttl_transmitter #(
        .CLOCKS_PER_BIT(CPB),
        .FIFO_DEPTH    (DEPTH)
    ) dut (
        .iBoardClock (clk),
        .iBoardReset (rst),
        .iData       (data),
        .iValid      (valid),
        .oReady      (ready),
        .oBusy       (busy),
        .oTTLSerialTX(tx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #(95000 * 10);
        $display("FAIL watchdog: simulation still running at cycle %0d, required finish", cyc);
        $fatal(1, "watchdog expired");
    end

    // Frame decoder: checks every cycle of every bit against the scoreboard head.
    always begin : monitor
        logic [10:0] bits;
        logic [7:0]  exp;
        logic        aborted;
        int          bad;
        @(negedge clk);
        if (!rst && tx === 1'b0) begin
            gaps.push_back(cyc - last_stop_cyc);
            vectors++;
            if (sb.size() == 0) begin
                miscompares++;
                $display("FAIL unexpected_frame: start bit at cycle %0d, required no frame", cyc);
                exp = 8'h00;
            end else begin
                exp = sb.pop_front();
            end
            bits = 11'h7ff;
            bits[0] = 1'b0;
            bits[8:1] = exp;
            if (NBITS == 11) bits[9] = ^exp;
            aborted = 1'b0;
            for (int k = 0; k < NBITS && !aborted; k++) begin
                bad = 0;
                for (int c = 0; c < CPB && !aborted; c++) begin
                    if (k != 0 || c != 0) @(negedge clk);
                    if (rst) aborted = 1'b1;
                    else if (tx !== bits[k]) bad++;
                end
                if (!aborted) begin
                    vectors++;
                    if (bad != 0) begin
                        miscompares++;
                        $display("FAIL frame_bit: byte %h bit %0d wrong in %0d of %0d cycles, required %b",
                                 exp, k, bad, CPB, bits[k]);
                    end
                end
            end
            if (!aborted) last_stop_cyc = cyc;
        end
    end

    task automatic push(input logic [7:0] b);
        data  = b;
        valid = 1'b1;
        sb.push_back(b);
        @(posedge clk); #1;
        valid = 1'b0;
    endtask

    task automatic wait_drain(input int limit);
        logic done;
        done = 1'b0;
        for (int i = 0; i < limit && !done; i++) begin
            @(posedge clk); #1;
            if (sb.size() == 0 && busy === 1'b0) done = 1'b1;
        end
        vectors++;
        if (!done) begin
            miscompares++;
            $display("FAIL drain: %0d bytes left busy=%b after %0d cycles, required empty and idle",
                     sb.size(), busy, limit);
        end
    endtask

    task automatic test_reset();
        rst = 1'b1; valid = 1'b1; data = 8'h55;
        repeat (3) @(posedge clk);
        #1;
        rst = 1'b0; valid = 1'b0;
        vectors += 3;
        if (tx !== 1'b1)    begin miscompares++; $display("FAIL reset_tx: got %b, required 1", tx); end
        if (busy !== 1'b0)  begin miscompares++; $display("FAIL reset_busy: got %b, required 0", busy); end
        if (ready !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b, required 1", ready); end
        @(posedge clk); #1;
        vectors++;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_priority: busy %b, required 0 (byte under reset dropped)", busy); end
    endtask

    task automatic test_idle();
        int bad_tx, bad_busy, bad_ready;
        bad_tx = 0; bad_busy = 0; bad_ready = 0;
        for (int i = 0; i < 1000; i++) begin
            @(negedge clk);
            if (tx !== 1'b1)    bad_tx++;
            if (busy !== 1'b0)  bad_busy++;
            if (ready !== 1'b1) bad_ready++;
        end
        @(posedge clk); #1;
        vectors += 3;
        if (bad_tx != 0)    begin miscompares++; $display("FAIL idle_tx: %0d cycles not high, required 0", bad_tx); end
        if (bad_busy != 0)  begin miscompares++; $display("FAIL idle_busy: %0d cycles busy, required 0", bad_busy); end
        if (bad_ready != 0) begin miscompares++; $display("FAIL idle_ready: %0d cycles not ready, required 0", bad_ready); end
    endtask

    task automatic test_single();
        push(8'h31);
        vectors += 2;
        if (tx !== 1'b1)   begin miscompares++; $display("FAIL single_lat_n: tx %b after accept edge, required 1", tx); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_q: busy %b with byte queued, required 1", busy); end
        @(posedge clk); #1;
        vectors++;
        if (tx !== 1'b0) begin miscompares++; $display("FAIL single_lat_n1: tx %b at N+1, required 0", tx); end
        repeat (FRAME - 1) @(posedge clk);
        #1;
        vectors++;
        if (busy !== 1'b1) begin miscompares++; $display("FAIL single_busy_end: busy %b one cycle before frame end, required 1", busy); end
        @(posedge clk); #1;
        vectors += 2;
        if (busy !== 1'b0) begin miscompares++; $display("FAIL single_busy_fall: busy %b after %0d cycles, required 0", busy, FRAME); end
        if (tx !== 1'b1)   begin miscompares++; $display("FAIL single_tx_idle: tx %b after frame, required 1", tx); end
    endtask

    task automatic test_back_to_back();
        gaps.delete();
        push(8'h2E);
        push(8'h41);
        push(8'h0D);
        push(8'h5A);
        wait_drain(5 * FRAME);
        vectors++;
        if (gaps.size() != 4) begin
            miscompares++;
            $display("FAIL b2b_frames: got %0d frames, required 4", gaps.size());
        end else begin
            for (int i = 1; i < 4; i++) begin
                vectors++;
                if (gaps[i] != 1) begin
                    miscompares++;
                    $display("FAIL b2b_gap: frame %0d gap %0d cycles, required 1", i, gaps[i]);
                end
            end
        end
    endtask

    task automatic test_fifo_full();
        push(8'h10);
        push(8'h21);
        push(8'h32);
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL full_ready3: ready %b with 3 queued, required 1", ready); end
        push(8'h43);
        push(8'h54);
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("FAIL full_ready4: ready %b with 4 queued, required 0", ready); end
        data = 8'hEE; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (FRAME - 5) @(posedge clk);
        #1;
        vectors++;
        if (ready !== 1'b0) begin miscompares++; $display("FAIL full_before_pop: ready %b, required 0", ready); end
        @(posedge clk); #1;
        vectors++;
        if (ready !== 1'b1) begin miscompares++; $display("FAIL full_after_pop: ready %b, required 1", ready); end
        wait_drain(6 * FRAME);
    endtask

    task automatic test_reset_mid_frame();
        int bad;
        push(8'hA5);
        push(8'h11);
        push(8'h22);
        repeat (4 * CPB + CPB / 2 - 1) @(posedge clk);
        #1;
        vectors += 2;
        if (tx !== 1'b0)   begin miscompares++; $display("FAIL mid_bit3: tx %b in bit 3 of A5, required 0", tx); end
        if (busy !== 1'b1) begin miscompares++; $display("FAIL mid_busy: busy %b mid frame, required 1", busy); end
        rst = 1'b1;
        @(posedge clk); #1;
        sb.delete();
        vectors += 3;
        if (tx !== 1'b1)    begin miscompares++; $display("FAIL abort_tx: tx %b at reset edge, required 1", tx); end
        if (busy !== 1'b0)  begin miscompares++; $display("FAIL abort_busy: busy %b at reset edge, required 0", busy); end
        if (ready !== 1'b1) begin miscompares++; $display("FAIL abort_ready: ready %b at reset edge, required 1", ready); end
        rst = 1'b0;
        bad = 0;
        for (int i = 0; i < 3 * FRAME; i++) begin
            @(negedge clk);
            if (tx !== 1'b1 || busy !== 1'b0) bad++;
        end
        @(posedge clk); #1;
        vectors++;
        if (bad != 0) begin miscompares++; $display("FAIL abort_quiet: %0d cycles active after reset, required 0", bad); end
    endtask

    task automatic test_parity();
        logic e0, e1;
        e0 = (NBITS == 11) ? ^8'h07 : 1'b1;
        e1 = (NBITS == 11) ? ^8'h03 : 1'b1;
        push(8'h07);
        push(8'h03);
        repeat (9 * CPB + CPB / 2) @(posedge clk);
        #1;
        vectors++;
        if (tx !== e0) begin miscompares++; $display("FAIL parity_07: bit9 %b, required %b", tx, e0); end
        repeat (FRAME) @(posedge clk);
        #1;
        vectors++;
        if (tx !== e1) begin miscompares++; $display("FAIL parity_03: bit9 %b, required %b", tx, e1); end
        wait_drain(3 * FRAME);
    endtask

    initial begin
        test_reset();
        test_idle();
        test_single();
        test_back_to_back();
        test_fifo_full();
        test_reset_mid_frame();
        test_parity();
        repeat (4) @(posedge clk);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
